// File: rtl/sha1_wb_stream.sv
// SHA-1 streaming accelerator behind a Wishbone slave: message words are queued in a FIFO,
// consumed 16 at a time by an iterative 80-round core, and chained into a readable digest.

module sha1_wb_stream_core (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [511:0] block_i,
  input  logic [159:0] h_i,
  output logic         finish_o,
  output logic [6:0]   round_o,
  output logic [159:0] state_o
);
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] w_q [16];
  logic [6:0]  t_q;
  logic        run_q, fin_q;
  logic [31:0] f, k, temp, wx;

  always_comb begin
    f = b_q ^ c_q ^ d_q;
    k = 32'hca62c1d6;
    if (t_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = 32'h5a827999;
    end else if (t_q < 7'd40) begin
      k = 32'h6ed9eba1;
    end else if (t_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = 32'h8f1bbcdc;
    end
    temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_q[0];
    // w_q[i] holds W[t+i]; the new tail word is W[t+16]
    wx = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {a_q, b_q, c_q, d_q, e_q} <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      t_q   <= '0;
      run_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (start_i) begin
        {a_q, b_q, c_q, d_q, e_q} <= h_i;
        for (int i = 0; i < 16; i++) w_q[i] <= block_i[511-32*i -: 32];
        t_q   <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        a_q <= temp;
        b_q <= a_q;
        c_q <= {b_q[1:0], b_q[31:2]};
        d_q <= c_q;
        e_q <= d_q;
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= {wx[30:0], wx[31]};
        if (t_q == 7'd79) begin
          run_q <= 1'b0;
          fin_q <= 1'b1;
          t_q   <= '0;
        end else begin
          t_q <= t_q + 7'd1;
        end
      end
    end
  end

  assign finish_o = fin_q;
  assign round_o  = t_q;
  assign state_o  = {a_q, b_q, c_q, d_q, e_q};
endmodule

module sha1_wb_stream #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          FIFO_DEPTH   = 32,
  parameter bit          IRQ_DEFAULT  = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        done,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HASH  = 3'd2;
  localparam logic [2:0] S_CHAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [31:0] IV [5] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                     32'h10325476, 32'hc3d2e1f0};

  logic [2:0]   state_q, state_d;
  logic         ack_q, ack_prev_q;
  logic [31:0]  dat_q, rdata, dig_word;
  logic [31:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]  wp_q, rp_q, level;
  logic [15:0]  level16, blocks_q;
  logic [3:0]   ld_cnt_q;
  logic [511:0] msg_q;
  logic [31:0]  h_q [5];
  logic [2:0]   didx_q;
  logic         started_q, final_q, irq_en_q, panic_q, ovf_q, core_start_q;
  logic [31:0]  off_w;
  logic [2:0]   reg_sel;
  logic         in_range, req, wr, wr_ctrl, wr_msg, rd_dig;
  logic         ctrl_start, ctrl_soft, full, pop, push, busy;
  logic         core_fin;
  logic [6:0]   core_round;
  logic [159:0] core_st;

  assign off_w    = wbs_adr_i - BASE_ADDRESS;
  assign reg_sel  = off_w[4:2];
  assign in_range = (off_w < 32'd24) && (off_w[1:0] == 2'b00);
  // A strobe still held in the cycle right after its acknowledge is not a new request.
  assign req      = wbs_stb_i & wbs_cyc_i & in_range & ~ack_q & ~ack_prev_q;
  assign wr       = req & wbs_we_i & (&wbs_sel_i);
  assign wr_ctrl  = wr && (reg_sel == 3'd2);
  assign wr_msg   = wr && (reg_sel == 3'd3);
  assign rd_dig   = req && !wbs_we_i && (reg_sel == 3'd4) && (state_q == S_DONE);
  assign ctrl_start = wr_ctrl & wbs_dat_i[0];
  assign ctrl_soft  = wr_ctrl & wbs_dat_i[1];

  assign level   = wp_q - rp_q;
  assign level16 = 16'(level);
  assign full    = level[AW];
  assign pop     = (state_q == S_LOAD);
  assign push    = wr_msg & (~full | pop);
  assign busy    = (state_q == S_LOAD) || (state_q == S_HASH) || (state_q == S_CHAIN);

  sha1_wb_stream_core u_core (
    .clk_i    (wb_clk_i),
    .rst_i    (reset | ctrl_start | ctrl_soft),
    .start_i  (core_start_q),
    .block_i  (msg_q),
    .h_i      ({h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]}),
    .finish_o (core_fin),
    .round_o  (core_round),
    .state_o  (core_st)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (started_q && level16 >= 16'd16) state_d = S_LOAD;
      S_LOAD:  if (ld_cnt_q == 4'd15) state_d = S_HASH;
      S_HASH:  if (core_fin) state_d = S_CHAIN;
      S_CHAIN: begin
        if (level16 >= 16'd16) state_d = S_LOAD;
        else if (final_q)      state_d = S_DONE;
        else                   state_d = S_IDLE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (ctrl_start || ctrl_soft) state_d = S_IDLE;
  end

  always_comb begin
    case (didx_q)
      3'd0:    dig_word = h_q[0];
      3'd1:    dig_word = h_q[1];
      3'd2:    dig_word = h_q[2];
      3'd3:    dig_word = h_q[3];
      default: dig_word = h_q[4];
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      3'd0:    rdata = 32'd6;
      3'd1:    rdata = 32'h53484131;
      3'd2:    rdata = {level16, 1'b0, core_round, 2'b00, irq_en_q, final_q,
                        (state_q == S_DONE), panic_q, ovf_q, busy};
      3'd3:    rdata = (wr_msg && push) ? 32'd1 : 32'h0fffffea;
      3'd4:    rdata = (state_q == S_DONE) ? dig_word : 32'hfffffff0;
      3'd5:    rdata = {16'h0, blocks_q};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      ack_prev_q   <= 1'b0;
      dat_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      ld_cnt_q     <= '0;
      msg_q        <= '0;
      blocks_q     <= '0;
      didx_q       <= '0;
      started_q    <= 1'b0;
      final_q      <= 1'b0;
      irq_en_q     <= IRQ_DEFAULT;
      panic_q      <= 1'b0;
      ovf_q        <= 1'b0;
      core_start_q <= 1'b0;
      for (int i = 0; i < 5; i++) h_q[i] <= IV[i];
    end else begin
      ack_q        <= req;
      ack_prev_q   <= ack_q;
      dat_q        <= req ? rdata : 32'h0;
      state_q      <= state_d;
      ld_cnt_q     <= (state_q == S_LOAD) ? ld_cnt_q + 4'd1 : 4'd0;
      core_start_q <= (state_q == S_LOAD) && (state_d == S_HASH);
      // First popped word ends up in the top 32 bits after 16 shifts
      if (pop) msg_q <= {msg_q[479:0], mem_q[rp_q[AW-1:0]]};
      if (ctrl_soft) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
      end
      if (wr_msg && !push) ovf_q <= 1'b1;
      if (wr_ctrl) begin
        started_q <= wbs_dat_i[0] | (started_q & ~wbs_dat_i[1]);
        final_q   <= wbs_dat_i[2] | (final_q & ~wbs_dat_i[0]);
        irq_en_q  <= wbs_dat_i[3];
      end
      if (ctrl_start) begin
        for (int i = 0; i < 5; i++) h_q[i] <= IV[i];
        blocks_q <= '0;
        didx_q   <= '0;
        panic_q  <= 1'b0;
      end else begin
        if (state_q == S_CHAIN) begin
          for (int i = 0; i < 5; i++) h_q[i] <= h_q[i] + core_st[159-32*i -: 32];
          if (blocks_q != 16'hffff) blocks_q <= blocks_q + 16'd1;
          if (state_d == S_DONE && level16 != 16'd0) panic_q <= 1'b1;
        end
        if (rd_dig) didx_q <= (didx_q == 3'd4) ? 3'd0 : didx_q + 3'd1;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign done      = (state_q == S_DONE);
  assign irq       = done & irq_en_q;
endmodule

// File: tb/tb_sha1_wb_stream.sv
// Directed bench for sha1_wb_stream: register map, one- and two-block digests, FIFO overflow,
// panic on a partial tail block, strobe hold, interrupt and reset abort.

module tb_sha1_wb_stream;
  localparam logic [31:0] BASE = 32'h30000024;
  localparam logic [4:0] R_NR = 5'h00, R_ID = 5'h04, R_CTRL = 5'h08;
  localparam logic [4:0] R_MSG = 5'h0c, R_DIG = 5'h10, R_BLK = 5'h14;
  localparam logic [31:0] DIG_ABC [5] = '{32'ha9993e36, 32'h4706816a, 32'hba3e2571,
                                          32'h7850c26c, 32'h9cd0d89d};
  localparam logic [31:0] DIG_TWO [5] = '{32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1,
                                          32'hf95129e5, 32'he54670f1};
  localparam logic [31:0] MSG2 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071};

  logic        clk, rst, stb, cyc, we, ack, done, irq;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  int          n_total, n_bad;

  sha1_wb_stream dut (
    .wb_clk_i  (clk),
    .reset     (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .done      (done),
    .irq       (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // driver tasks
  task automatic wb_xfer(input logic w, input logic [4:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    logic got;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + 32'(off); wdat = d; sel = s;
    got = 1'b0;
    rd  = 32'h0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        rd  = rdat;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_total++; n_bad++;
      $display("FAIL wb_ack off=%0h: got no ack, required ack within 10 cycles", off);
    end
  endtask

  task automatic wb_write(input logic [4:0] off, input logic [31:0] d, output logic [31:0] rd);
    wb_xfer(1'b1, off, d, 4'hf, rd);
  endtask

  task automatic wb_read(input logic [4:0] off, output logic [31:0] rd);
    wb_xfer(1'b0, off, 32'h0, 4'hf, rd);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (!done) begin
      n_bad++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, budget);
    end
  endtask

  function automatic logic [31:0] abc_word(input int i);
    if (i == 0)  return 32'h61626380;
    if (i == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  function automatic logic [31:0] two_word(input int i);
    if (i < 14)  return MSG2[i];
    if (i == 14) return 32'h80000000;
    if (i == 31) return 32'h000001c0;
    return 32'h0;
  endfunction

  task automatic run_abc(input logic [31:0] extra);
    logic [31:0] rd;
    wb_write(R_CTRL, 32'h1 | extra, rd);
    for (int i = 0; i < 16; i++) wb_write(R_MSG, abc_word(i), rd);
    wb_write(R_CTRL, 32'h4 | extra, rd);
    wait_done(400);
  endtask

  // scenario tasks
  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ack !== 1'b0)   begin n_bad++; $display("FAIL rst_ack got=%b want=0", ack); end
    n_total++; if (rdat !== 32'h0) begin n_bad++; $display("FAIL rst_dat got=%h want=0", rdat); end
    n_total++; if (done !== 1'b0)  begin n_bad++; $display("FAIL rst_done got=%b want=0", done); end
    n_total++; if (irq !== 1'b0)   begin n_bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    rst = 1'b0;
    wb_read(R_NR, rd);
    n_total++; if (rd !== 32'd6) begin n_bad++; $display("FAIL nr got=%h want=6", rd); end
    wb_read(R_ID, rd);
    n_total++; if (rd !== 32'h53484131) begin n_bad++; $display("FAIL id got=%h want=53484131", rd); end
    wb_read(R_MSG, rd);
    n_total++; if (rd !== 32'h0fffffea) begin n_bad++; $display("FAIL msg_rd got=%h want=0fffffea", rd); end
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL ctrl_rst got=%h want=0", rd); end
    wb_read(R_BLK, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL blocks_rst got=%h want=0", rd); end
  endtask

  task automatic test_byte_sel();
    logic [31:0] rd;
    wb_xfer(1'b1, R_MSG, 32'hdeadbeef, 4'b0111, rd);
    wb_xfer(1'b1, R_CTRL, 32'h8, 4'b1110, rd);
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL byte_sel got=%h want=0", rd); end
  endtask

  task automatic test_digest_early_and_hold();
    logic [31:0] rd, cap;
    int acks;
    pulse_reset();
    wb_read(R_DIG, rd);
    n_total++; if (rd !== 32'hfffffff0) begin n_bad++; $display("FAIL dig_early got=%h want=fffffff0", rd); end
    run_abc(32'h0);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'(R_DIG); sel = 4'hf;
    acks = 0; cap = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) begin acks++; cap = rdat; end
    end
    stb = 1'b0; cyc = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_total++; if (acks !== 1) begin n_bad++; $display("FAIL hold_acks got=%0d want=1", acks); end
    n_total++; if (cap !== DIG_ABC[0]) begin n_bad++; $display("FAIL hold_data got=%h want=%h", cap, DIG_ABC[0]); end
    wb_read(R_DIG, rd);
    n_total++; if (rd !== DIG_ABC[1]) begin n_bad++; $display("FAIL hold_next got=%h want=%h", rd, DIG_ABC[1]); end
  endtask

  task automatic test_abc();
    logic [31:0] rd;
    pulse_reset();
    run_abc(32'h0);
    wb_read(R_BLK, rd);
    n_total++; if (rd !== 32'd1) begin n_bad++; $display("FAIL abc_blocks got=%h want=1", rd); end
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h18) begin n_bad++; $display("FAIL abc_ctrl got=%h want=18", rd); end
    for (int i = 0; i < 6; i++) begin
      wb_read(R_DIG, rd);
      n_total++;
      if (rd !== DIG_ABC[i % 5]) begin
        n_bad++; $display("FAIL abc_digest[%0d] got=%h want=%h", i, rd, DIG_ABC[i % 5]);
      end
    end
  endtask

  task automatic test_two_block();
    logic [31:0] rd;
    pulse_reset();
    wb_write(R_CTRL, 32'h1, rd);
    for (int i = 0; i < 32; i++) wb_write(R_MSG, two_word(i), rd);
    wb_write(R_CTRL, 32'h4, rd);
    wait_done(600);
    wb_read(R_BLK, rd);
    n_total++; if (rd !== 32'd2) begin n_bad++; $display("FAIL two_blocks got=%h want=2", rd); end
    for (int i = 0; i < 5; i++) begin
      wb_read(R_DIG, rd);
      n_total++;
      if (rd !== DIG_TWO[i]) begin
        n_bad++; $display("FAIL two_digest[%0d] got=%h want=%h", i, rd, DIG_TWO[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, first_rd, last_ok;
    pulse_reset();
    for (int i = 0; i < 33; i++) begin
      wb_write(R_MSG, 32'h1000 + 32'(i), rd);
      if (i == 0)  first_rd = rd;
      if (i == 31) last_ok = rd;
    end
    n_total++; if (first_rd !== 32'd1) begin n_bad++; $display("FAIL ovf_first got=%h want=1", first_rd); end
    n_total++; if (last_ok !== 32'd1) begin n_bad++; $display("FAIL ovf_32nd got=%h want=1", last_ok); end
    n_total++; if (rd !== 32'h0fffffea) begin n_bad++; $display("FAIL ovf_drop got=%h want=0fffffea", rd); end
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h00200002) begin n_bad++; $display("FAIL ovf_ctrl got=%h want=00200002", rd); end
    wb_write(R_CTRL, 32'h2, rd);
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h00000002) begin n_bad++; $display("FAIL soft_rst got=%h want=00000002", rd); end
  endtask

  task automatic test_panic();
    logic [31:0] rd;
    pulse_reset();
    wb_write(R_CTRL, 32'h1, rd);
    for (int i = 0; i < 20; i++) wb_write(R_MSG, (i < 16) ? abc_word(i) : 32'h0, rd);
    wb_write(R_CTRL, 32'h4, rd);
    wait_done(400);
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h0004001c) begin n_bad++; $display("FAIL panic_ctrl got=%h want=0004001c", rd); end
    wb_read(R_BLK, rd);
    n_total++; if (rd !== 32'd1) begin n_bad++; $display("FAIL panic_blocks got=%h want=1", rd); end
  endtask

  task automatic test_irq_reset();
    logic [31:0] rd;
    pulse_reset();
    run_abc(32'h8);
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq got=%b want=1", irq); end
    wb_write(R_CTRL, 32'h9, rd);
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got=%b want=0", irq); end
    for (int i = 0; i < 16; i++) wb_write(R_MSG, abc_word(i), rd);
    repeat (30) @(posedge clk);
    wb_read(R_CTRL, rd);
    n_total++; if (rd[0] !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b want=1", rd[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({ack, rdat, done, irq} !== 35'h0) begin
      n_bad++; $display("FAIL abort_outputs got ack=%b dat=%h done=%b irq=%b want all 0", ack, rdat, done, irq);
    end
    rst = 1'b0;
    wb_read(R_CTRL, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_ctrl got=%h want=0", rd); end
    wb_read(R_DIG, rd);
    n_total++; if (rd !== 32'hfffffff0) begin n_bad++; $display("FAIL abort_dig got=%h want=fffffff0", rd); end
  endtask

  // sequence and final report
  initial begin
    n_total = 0; n_bad = 0;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    test_reset();
    test_byte_sel();
    test_abc();
    test_two_block();
    test_overflow();
    test_panic();
    test_digest_early_and_hold();
    test_irq_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
